// File: rtl/dmem_arbiter_if.sv
// Per-core data-memory request port between one MIPS core and the shared-dmem arbiter.
// The core drives the request side (master); the arbiter returns data, stall and sc status (slave).
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic        ll;
    logic        sc;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        scok;

    modport master (output req, we, ll, sc, adr, wd, input rd, stall, scok);
    modport slave  (input req, we, ll, sc, adr, wd, output rd, stall, scok);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter granting one of two cores access to a shared dmem each cycle,
// with per-core LL/SC reservations and a saturating contention counter.
module dmem_arbiter #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   a,
    dmem_arbiter_if.slave   b,
    output logic            mem_we,
    output logic [31:0]     mem_adr,
    output logic [31:0]     mem_wd,
    input  logic [31:0]     mem_rd,
    output logic [CNTW-1:0] cont_cnt
);

    // state  | meaning
    // LAST_A | core A held the most recent grant; B wins the next contention
    // LAST_B | core B held the most recent grant; A wins the next contention
    typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

    last_e            last_q, last_d;
    logic             resv_v_a_q, resv_v_a_d;
    logic             resv_v_b_q, resv_v_b_d;
    logic [29:0]      resv_adr_a_q, resv_adr_a_d;
    logic [29:0]      resv_adr_b_q, resv_adr_b_d;
    logic [CNTW-1:0]  cont_cnt_q, cont_cnt_d;

    logic gnt_a, gnt_b;
    logic scok_a, scok_b;

    // Grant and memory-bus steering; everything is forced idle while rst is high.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (a.req && (!b.req || last_q == LAST_B)) begin
                gnt_a = 1'b1;
            end else if (b.req) begin
                gnt_b = 1'b1;
            end
        end

        scok_a = gnt_a && a.sc && resv_v_a_q && (a.adr[31:2] == resv_adr_a_q);
        scok_b = gnt_b && b.sc && resv_v_b_q && (b.adr[31:2] == resv_adr_b_q);

        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (gnt_a) begin
            mem_we  = a.we && (!a.sc || scok_a);
            mem_adr = a.adr;
            mem_wd  = a.wd;
        end else if (gnt_b) begin
            mem_we  = b.we && (!b.sc || scok_b);
            mem_adr = b.adr;
            mem_wd  = b.wd;
        end

        a.rd    = gnt_a ? mem_rd : '0;
        b.rd    = gnt_b ? mem_rd : '0;
        a.stall = !rst && a.req && !gnt_a;
        b.stall = !rst && b.req && !gnt_b;
        a.scok  = scok_a;
        b.scok  = scok_b;
    end

    always_comb begin
        last_d = last_q;
        if (gnt_a) begin
            last_d = LAST_A;
        end else if (gnt_b) begin
            last_d = LAST_B;
        end

        resv_v_a_d   = resv_v_a_q;
        resv_adr_a_d = resv_adr_a_q;
        if (gnt_a && a.ll) begin
            resv_v_a_d   = 1'b1;
            resv_adr_a_d = a.adr[31:2];
        end
        if (gnt_a && a.sc) begin
            resv_v_a_d = 1'b0;
        end
        // Only the other core's performed writes break a reservation.
        if (gnt_b && mem_we && (b.adr[31:2] == resv_adr_a_q)) begin
            resv_v_a_d = 1'b0;
        end

        resv_v_b_d   = resv_v_b_q;
        resv_adr_b_d = resv_adr_b_q;
        if (gnt_b && b.ll) begin
            resv_v_b_d   = 1'b1;
            resv_adr_b_d = b.adr[31:2];
        end
        if (gnt_b && b.sc) begin
            resv_v_b_d = 1'b0;
        end
        if (gnt_a && mem_we && (a.adr[31:2] == resv_adr_b_q)) begin
            resv_v_b_d = 1'b0;
        end

        cont_cnt_d = cont_cnt_q;
        if (a.req && b.req && (cont_cnt_q != '1)) begin
            cont_cnt_d = cont_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= LAST_B;
            resv_v_a_q   <= 1'b0;
            resv_v_b_q   <= 1'b0;
            resv_adr_a_q <= '0;
            resv_adr_b_q <= '0;
            cont_cnt_q   <= '0;
        end else begin
            last_q       <= last_d;
            resv_v_a_q   <= resv_v_a_d;
            resv_v_b_q   <= resv_v_b_d;
            resv_adr_a_q <= resv_adr_a_d;
            resv_adr_b_q <= resv_adr_b_d;
            cont_cnt_q   <= cont_cnt_d;
        end
    end

    assign cont_cnt = cont_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a per-core reference model of arbitration and LL/SC.
module tb_dmem_arbiter;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk;
    logic            rst;
    logic            mem_we;
    logic [31:0]     mem_adr;
    logic [31:0]     mem_wd;
    logic [31:0]     mem_rd;
    logic [CNTW-1:0] cont_cnt;

    dmem_arbiter_if a_if();
    dmem_arbiter_if b_if();

    dmem_arbiter #(.CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a_if),
        .b        (b_if),
        .mem_we   (mem_we),
        .mem_adr  (mem_adr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .cont_cnt (cont_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared dmem: combinational read, write on the rising edge.
    logic [31:0] env_mem [64];
    assign mem_rd = env_mem[mem_adr[7:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_adr[7:2]] <= mem_wd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: core index 0 = A, 1 = B.
    int          last_m = 1;
    bit          rv_m [2];
    logic [29:0] ra_m [2];
    int          cnt_m = 0;
    logic [31:0] mm [64];
    bit          stall_m [2];

    always @(negedge clk) begin
        bit          rq [2], we [2], ll [2], sc [2];
        logic [31:0] ad [2], wd [2];
        logic [31:0] e_rd [2];
        bit          e_st [2], e_ok [2];
        bit          e_we;
        logic [31:0] e_adr, e_wd;
        int          w;

        rq[0] = a_if.req; we[0] = a_if.we; ll[0] = a_if.ll; sc[0] = a_if.sc;
        ad[0] = a_if.adr; wd[0] = a_if.wd;
        rq[1] = b_if.req; we[1] = b_if.we; ll[1] = b_if.ll; sc[1] = b_if.sc;
        ad[1] = b_if.adr; wd[1] = b_if.wd;

        for (int c = 0; c < 2; c++) begin
            e_rd[c] = '0; e_st[c] = 1'b0; e_ok[c] = 1'b0;
        end
        e_we = 1'b0; e_adr = '0; e_wd = '0; w = -1;

        if (!rst) begin
            if (rq[0] && rq[1]) w = 1 - last_m;
            else if (rq[0])     w = 0;
            else if (rq[1])     w = 1;
            if (w >= 0) begin
                e_ok[w] = sc[w] && rv_m[w] && (ra_m[w] == ad[w][31:2]);
                e_we    = we[w] && (!sc[w] || e_ok[w]);
                e_adr   = ad[w];
                e_wd    = wd[w];
                e_rd[w] = mm[ad[w][7:2]];
            end
            for (int c = 0; c < 2; c++) e_st[c] = rq[c] && (w != c);
        end

        check("a_stall", {31'd0, a_if.stall}, {31'd0, e_st[0]});
        check("b_stall", {31'd0, b_if.stall}, {31'd0, e_st[1]});
        check("a_scok",  {31'd0, a_if.scok},  {31'd0, e_ok[0]});
        check("b_scok",  {31'd0, b_if.scok},  {31'd0, e_ok[1]});
        check("a_rd",    a_if.rd, e_rd[0]);
        check("b_rd",    b_if.rd, e_rd[1]);
        check("mem_we",  {31'd0, mem_we}, {31'd0, e_we});
        check("mem_adr", mem_adr, e_adr);
        check("mem_wd",  mem_wd, e_wd);
        check("cont_cnt", 32'(cont_cnt), 32'(cnt_m));

        if (rst) begin
            last_m = 1; rv_m[0] = 1'b0; rv_m[1] = 1'b0; cnt_m = 0;
        end else begin
            if (rq[0] && rq[1] && cnt_m < CMAX) cnt_m++;
            if (w >= 0) begin
                last_m = w;
                if (ll[w]) begin rv_m[w] = 1'b1; ra_m[w] = ad[w][31:2]; end
                if (sc[w]) rv_m[w] = 1'b0;
                if (e_we) begin
                    mm[ad[w][7:2]] = wd[w];
                    if (rv_m[1-w] && ra_m[1-w] == ad[w][31:2]) rv_m[1-w] = 1'b0;
                end
            end
        end
        stall_m[0] = e_st[0];
        stall_m[1] = e_st[1];
    end

    // kind: 0 idle, 1 lw, 2 sw, 3 ll, 4 sc
    task automatic op(input int c, input int kind, input logic [31:0] adr, input logic [31:0] wd);
        bit r, w, l, s;
        r = (kind != 0);
        w = (kind == 2) || (kind == 4);
        l = (kind == 3);
        s = (kind == 4);
        if (c == 0) begin
            a_if.req = r; a_if.we = w; a_if.ll = l; a_if.sc = s; a_if.adr = adr; a_if.wd = wd;
        end else begin
            b_if.req = r; b_if.we = w; b_if.ll = l; b_if.sc = s; b_if.adr = adr; b_if.wd = wd;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = '0;
            mm[i] = '0;
        end
        rv_m[0] = 1'b0; rv_m[1] = 1'b0; ra_m[0] = '0; ra_m[1] = '0;
        stall_m[0] = 1'b0; stall_m[1] = 1'b0;
        rst = 1'b1;
        op(0, 0, 0, 0);
        op(1, 0, 0, 0);
        adv(); adv();

        // Requests during reset are suppressed.
        op(0, 1, 32'h0, 0); op(1, 1, 32'h0, 0);
        tick();
        check("rst_a_stall", {31'd0, a_if.stall}, 32'd0);
        check("rst_b_stall", {31'd0, b_if.stall}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_cont", 32'(cont_cnt), 32'd0);
        adv();

        // Uncontended store then load.
        rst = 1'b0;
        op(0, 2, 32'h0, 32'h12345678); op(1, 0, 0, 0);
        tick();
        check("sw_a_stall", {31'd0, a_if.stall}, 32'd0);
        check("sw_mem_we", {31'd0, mem_we}, 32'd1);
        adv();
        op(0, 1, 32'h0, 0);
        tick();
        check("lw_a_rd", a_if.rd, 32'h12345678);
        check("lw_cont", 32'(cont_cnt), 32'd0);
        adv();

        // Contention right after reset: A first, then B.
        rst = 1'b1; op(0, 0, 0, 0); tick(); adv(); rst = 1'b0;
        op(0, 1, 32'h0, 0); op(1, 1, 32'h0, 0);
        tick();
        check("c1_a_stall", {31'd0, a_if.stall}, 32'd0);
        check("c1_b_stall", {31'd0, b_if.stall}, 32'd1);
        adv();
        op(0, 0, 0, 0);
        tick();
        check("c2_b_stall", {31'd0, b_if.stall}, 32'd0);
        check("c2_b_rd", b_if.rd, 32'h12345678);
        check("c2_cont", 32'(cont_cnt), 32'd1);
        adv();

        // Six cycles of continuous contention alternate grants.
        rst = 1'b1; op(1, 0, 0, 0); tick(); adv(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            op(0, 1, 32'h0, 0); op(1, 1, 32'h0, 0);
            tick();
            check("alt_a_stall", {31'd0, a_if.stall}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check("alt_b_stall", {31'd0, b_if.stall}, (i % 2 == 0) ? 32'd1 : 32'd0);
            adv();
        end
        op(0, 0, 0, 0); op(1, 0, 0, 0);
        tick();
        check("alt_cont", 32'(cont_cnt), 32'd6);
        adv();

        // LL/SC success, then a repeated sc fails.
        op(0, 3, 32'h40, 0); tick(); adv();
        op(0, 4, 32'h40, 32'd1);
        tick();
        check("sc1_scok", {31'd0, a_if.scok}, 32'd1);
        check("sc1_mem_we", {31'd0, mem_we}, 32'd1);
        adv();
        op(0, 1, 32'h40, 0); tick(); check("sc1_rd", a_if.rd, 32'd1); adv();
        op(0, 4, 32'h40, 32'd2);
        tick();
        check("sc2_scok", {31'd0, a_if.scok}, 32'd0);
        check("sc2_mem_we", {31'd0, mem_we}, 32'd0);
        adv();
        op(0, 1, 32'h40, 0); tick(); check("sc2_rd", a_if.rd, 32'd1); adv();

        // Reservation broken by B store to the same word; kept for a different word.
        op(0, 3, 32'h40, 0); tick(); adv();
        op(0, 0, 0, 0); op(1, 2, 32'h42, 32'd7); tick(); adv();
        op(1, 0, 0, 0); op(0, 4, 32'h40, 32'd1);
        tick(); check("brk_scok", {31'd0, a_if.scok}, 32'd0); adv();
        op(0, 1, 32'h40, 0); tick(); check("brk_rd", a_if.rd, 32'd7); adv();
        op(0, 3, 32'h40, 0); tick(); adv();
        op(0, 0, 0, 0); op(1, 2, 32'h44, 32'd9); tick(); adv();
        op(1, 0, 0, 0); op(0, 4, 32'h40, 32'd1);
        tick(); check("keep_scok", {31'd0, a_if.scok}, 32'd1); adv();

        // Reset between ll and sc drops the reservation and re-seeds arbitration.
        op(0, 3, 32'h40, 0); tick(); adv();
        rst = 1'b1; op(0, 0, 0, 0); tick(); adv(); rst = 1'b0;
        op(0, 4, 32'h40, 32'd3); op(1, 1, 32'h0, 0);
        tick();
        check("rsc_scok", {31'd0, a_if.scok}, 32'd0);
        check("rsc_cont", 32'(cont_cnt), 32'd0);
        check("rsc_a_stall", {31'd0, a_if.stall}, 32'd0);
        check("rsc_b_stall", {31'd0, b_if.stall}, 32'd1);
        adv();
        op(0, 0, 0, 0); tick(); adv();
        op(1, 0, 0, 0);

        // Random traffic on a few shared words; stalled cores hold their request.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < 2; c++) begin
                if (!stall_m[c]) begin
                    if ($urandom_range(0, 3) == 0) op(c, 0, 0, 0);
                    else op(c, int'($urandom_range(1, 4)), 32'h40 + 32'($urandom_range(0, 15)), $urandom);
                end
            end
            tick();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
